// File: rtl/instruction_fetch.sv
// Fetch stage for a synchronous, one-cycle-latency program ROM with stall and branch redirect.
// Optional delivered-instruction counter on fetch_count_o when FETCH_PERF_EN is defined.
module instruction_fetch #(
    parameter int                    WORD_SIZE = 20,
    parameter int                    ADDR_SIZE = 16,
    parameter logic [ADDR_SIZE-1:0]  RESET_PC  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_SIZE-1:0]  rom_addr_o,
    input  logic [WORD_SIZE-1:0]  rom_data_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [ADDR_SIZE-1:0]  redirect_pc_i,
    output logic [WORD_SIZE-1:0]  instr_o,
    output logic [ADDR_SIZE-1:0]  instr_pc_o,
    output logic                  instr_valid_o
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]           fetch_count_o
`endif
);

    localparam logic [1:0] MODE_RUN   = 2'd0;
    localparam logic [1:0] MODE_STALL = 2'd1;
    localparam logic [1:0] MODE_REDIR = 2'd2;

    localparam logic [ADDR_SIZE-1:0] PC_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    logic [ADDR_SIZE-1:0] fetch_pc_r;
    logic [ADDR_SIZE-1:0] pend_pc_r;
    logic                 pend_valid_r;
    logic [WORD_SIZE-1:0] instr_r;
    logic [ADDR_SIZE-1:0] instr_pc_r;
    logic                 instr_valid_r;
    logic [1:0]           mode_s;
    logic [ADDR_SIZE-1:0] fetch_pc_inc_s;
    logic [ADDR_SIZE-1:0] redirect_pc_inc_s;
    logic [ADDR_SIZE-1:0] rom_addr_s;

    // Resolve this cycle's action: redirect beats stall beats run.
    always_comb begin
        mode_s = MODE_RUN;
        if (redirect_i) begin
            mode_s = MODE_REDIR;
        end else if (stall_i) begin
            mode_s = MODE_STALL;
        end else begin
            mode_s = MODE_RUN;
        end
    end

    // Wrapping increments and the ROM address mux; a stall re-reads P so rom_data_i keeps mem[P].
    always_comb begin
        fetch_pc_inc_s    = fetch_pc_r + PC_ONE;
        redirect_pc_inc_s = redirect_pc_i + PC_ONE;
        rom_addr_s        = fetch_pc_r;
        case (mode_s)
            MODE_REDIR: rom_addr_s = redirect_pc_i;
            MODE_STALL: rom_addr_s = pend_pc_r;
            MODE_RUN:   rom_addr_s = fetch_pc_r;
            default:    rom_addr_s = fetch_pc_r;
        endcase
    end

    assign rom_addr_o = rom_addr_s;

    // PC tracking and the registered decode-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r    <= RESET_PC;
            pend_pc_r     <= RESET_PC;
            pend_valid_r  <= 1'b0;
            instr_r       <= {WORD_SIZE{1'b0}};
            instr_pc_r    <= {ADDR_SIZE{1'b0}};
            instr_valid_r <= 1'b0;
        end else begin
            case (mode_s)
                MODE_REDIR: begin
                    instr_valid_r <= 1'b0;
                    pend_pc_r     <= redirect_pc_i;
                    pend_valid_r  <= 1'b1;
                    fetch_pc_r    <= redirect_pc_inc_s;
                end
                MODE_STALL: begin
                    instr_valid_r <= instr_valid_r;
                end
                MODE_RUN: begin
                    instr_r       <= rom_data_i;
                    instr_pc_r    <= pend_pc_r;
                    instr_valid_r <= pend_valid_r;
                    pend_pc_r     <= fetch_pc_r;
                    pend_valid_r  <= 1'b1;
                    fetch_pc_r    <= fetch_pc_inc_s;
                end
                default: begin
                    instr_valid_r <= instr_valid_r;
                end
            endcase
        end
    end

    assign instr_o       = instr_r;
    assign instr_pc_o    = instr_pc_r;
    assign instr_valid_o = instr_valid_r;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count_r;

    // Count instructions decode actually consumes; saturate rather than wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count_r <= 16'h0000;
        end else if (instr_valid_r && (mode_s == MODE_RUN) && (fetch_count_r != 16'hFFFF)) begin
            fetch_count_r <= fetch_count_r + 16'h0001;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    assign fetch_count_o = fetch_count_r;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural one-cycle ROM where ROM[i] = i.
module tb_instruction_fetch;

    logic        clk;
    logic        reset_n;
    logic [15:0] rom_addr;
    logic [19:0] rom_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [19:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
`endif

    int n_checks;
    int n_pass;

    instruction_fetch #(
        .WORD_SIZE (20),
        .ADDR_SIZE (16),
        .RESET_PC  (16'h0010)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rom_addr_o    (rom_addr),
        .rom_data_i    (rom_data),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (instr_valid)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count_o (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one cycle of latency, contents equal to the address.
    always @(posedge clk) rom_data <= {4'h0, rom_addr};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [15:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [15:0] pc);
        check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
        if (v) begin
            check({tag, ".pc"}, {16'd0, instr_pc}, {16'd0, pc});
            check({tag, ".instr"}, {12'd0, instr}, {16'd0, pc});
        end
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        tick();
        tick();
        check("rst.valid", {31'd0, instr_valid}, 32'd0);
        check("rst.instr", {12'd0, instr}, 32'd0);
        check("rst.pc", {16'd0, instr_pc}, 32'd0);
        check("rst.rom_addr", {16'd0, rom_addr}, 32'h10);
        reset_n = 1'b1;

        // 1: startup latency, then sequential delivery
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        expect_out("t1.e1", 1'b0, 16'h0000);
        check("t1.rom_addr", {16'd0, rom_addr}, 32'h11);
        tick();
        expect_out("t1.e2", 1'b1, 16'h0010);
        tick();
        expect_out("t1.e3", 1'b1, 16'h0011);
        tick();
        expect_out("t1.e4", 1'b1, 16'h0012);

        // 2: three-cycle stall holds 0x12
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'h0000);
            check("t2.rom_addr", {16'd0, rom_addr}, 32'h13);
            tick();
            expect_out("t2.hold", 1'b1, 16'h0012);
        end
        drive(1'b0, 1'b0, 16'h0000);
        check("t2.rel_addr", {16'd0, rom_addr}, 32'h14);
        tick();
        expect_out("t2.a", 1'b1, 16'h0013);
        tick();
        expect_out("t2.b", 1'b1, 16'h0014);

        // 3: redirect to 0x200 flushes 0x15
        drive(1'b0, 1'b1, 16'h0200);
        check("t3.rom_addr", {16'd0, rom_addr}, 32'h200);
        tick();
        expect_out("t3.flush", 1'b0, 16'h0000);
        check("t3.pc_hold", {16'd0, instr_pc}, 32'h14);
        drive(1'b0, 1'b0, 16'h0000);
        check("t3.next_addr", {16'd0, rom_addr}, 32'h201);
        tick();
        expect_out("t3.a", 1'b1, 16'h0200);
        tick();
        expect_out("t3.b", 1'b1, 16'h0201);

        // 4: address wrap past 0xFFFF
        drive(1'b0, 1'b1, 16'hFFFE);
        tick();
        expect_out("t4.flush", 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        expect_out("t4.a", 1'b1, 16'hFFFE);
        tick();
        expect_out("t4.b", 1'b1, 16'hFFFF);
        tick();
        expect_out("t4.c", 1'b1, 16'h0000);
        tick();
        expect_out("t4.d", 1'b1, 16'h0001);

        // 5: redirect together with stall, then two more stall cycles
        drive(1'b1, 1'b1, 16'h0300);
        check("t5.rom_addr", {16'd0, rom_addr}, 32'h300);
        tick();
        expect_out("t5.s0", 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 16'h0000);
        check("t5.stall_addr", {16'd0, rom_addr}, 32'h300);
        tick();
        expect_out("t5.s1", 1'b0, 16'h0000);
        tick();
        expect_out("t5.s2", 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000);
        check("t5.rel_addr", {16'd0, rom_addr}, 32'h301);
        tick();
        expect_out("t5.a", 1'b1, 16'h0300);
        tick();
        expect_out("t5.b", 1'b1, 16'h0301);

        // reset asserted mid-stall clears immediately
        drive(1'b1, 1'b0, 16'h0000);
        tick();
        expect_out("t5.hold", 1'b1, 16'h0301);
        reset_n = 1'b0;
        #1;
        check("rst2.valid", {31'd0, instr_valid}, 32'd0);
        check("rst2.pc", {16'd0, instr_pc}, 32'd0);
        check("rst2.rom_addr", {16'd0, rom_addr}, 32'h10);
        tick();
        drive(1'b0, 1'b0, 16'h0000);
        reset_n = 1'b1;

        // 6: five deliveries with two stalls interleaved
        tick();
        expect_out("t6.e1", 1'b0, 16'h0000);
        tick();
        expect_out("t6.e2", 1'b1, 16'h0010);
        tick();
        expect_out("t6.e3", 1'b1, 16'h0011);
        drive(1'b1, 1'b0, 16'h0000);
        tick();
        expect_out("t6.st1", 1'b1, 16'h0011);
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        expect_out("t6.e5", 1'b1, 16'h0012);
        tick();
        expect_out("t6.e6", 1'b1, 16'h0013);
        drive(1'b1, 1'b0, 16'h0000);
        tick();
        expect_out("t6.st2", 1'b1, 16'h0013);
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        expect_out("t6.e8", 1'b1, 16'h0014);
        tick();
        expect_out("t6.e9", 1'b1, 16'h0015);
`ifdef FETCH_PERF_EN
        check("t6.count", {16'd0, fetch_count}, 32'd5);
`endif
        reset_n = 1'b0;
        #1;
        check("t6.rst_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        check("t6.rst_count", {16'd0, fetch_count}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
